// File: rtl/countone_mul_pkg.sv
// Shared constants and per-beat mode bits for the countone multiply pipeline.
package countone_mul_pkg;

  localparam int MUL_STAGES_MIN = 2;
  localparam int MUL_STAGES_MAX = 8;

  typedef struct packed {
    logic signed_en;
    logic acc_en;
  } mul_mode_t;

endpackage

// File: rtl/countone_mul_delay.sv
// Valid+payload shift register, DEPTH cycles, advancing only when adv_i is high.
// Backpressure: adv_i low freezes every slot; DEPTH=0 is a wire.
module countone_mul_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  if (DEPTH == 0) begin : g_wire
    assign vld_o = vld_i;
    assign dat_o = dat_i;
  end else begin : g_sr
    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
      end else if (adv_i) begin
        vld_q[0] <= vld_i;
        dat_q[0] <= dat_i;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/countone_mul_pipe.sv
// Pipelined signed/unsigned multiply-accumulate; result STAGES advancing cycles after accept.
// Backpressure: out_valid & ~out_ready or ce=0 freezes all stages; in_ready = ce & ~stall.
module countone_mul_pipe
  import countone_mul_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int STAGES    = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_signed,
  input  logic                 in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);

  localparam int PW = A_WIDTH + B_WIDTH;

  if (STAGES < MUL_STAGES_MIN || STAGES > MUL_STAGES_MAX) begin : g_bad_stages
    $error("countone_mul_pipe: STAGES must lie in 2..8");
  end
  if (ACC_WIDTH < PW) begin : g_bad_acc
    $error("countone_mul_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end

  logic advance;
  assign advance  = ce & ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // Stage 1: operands widened by one bit so a single signed multiply covers both modes.
  logic               s1_vld_q;
  logic [A_WIDTH:0]   a_ext_q, a_ext_d;
  logic [B_WIDTH:0]   b_ext_q, b_ext_d;
  mul_mode_t          mode1_q, mode1_d;

  always_comb begin
    a_ext_d = {in_signed & in_a[A_WIDTH-1], in_a};
    b_ext_d = {in_signed & in_b[B_WIDTH-1], in_b};
    mode1_d = '{signed_en: in_signed, acc_en: in_acc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      a_ext_q  <= '0;
      b_ext_q  <= '0;
      mode1_q  <= '0;
    end else if (advance) begin
      s1_vld_q <= in_valid;
      a_ext_q  <= a_ext_d;
      b_ext_q  <= b_ext_d;
      mode1_q  <= mode1_d;
    end
  end

  // Only the low PW bits are kept, so extending both operands to PW makes the multiply exact.
  logic [PW-1:0] a_mul, b_mul, prod_c;
  assign a_mul  = {{(B_WIDTH-1){a_ext_q[A_WIDTH]}}, a_ext_q};
  assign b_mul  = {{(A_WIDTH-1){b_ext_q[B_WIDTH]}}, b_ext_q};
  assign prod_c = a_mul * b_mul;

  logic          fin_vld;
  logic [PW-1:0] fin_prod;
  mul_mode_t     fin_mode;

  if (STAGES == 2) begin : g_short
    assign fin_vld  = s1_vld_q;
    assign fin_prod = prod_c;
    assign fin_mode = mode1_q;
  end else begin : g_long
    logic          s2_vld_q;
    logic [PW-1:0] s2_prod_q;
    mul_mode_t     s2_mode_q;
    logic [PW+1:0] fin_dat;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_vld_q  <= 1'b0;
        s2_prod_q <= '0;
        s2_mode_q <= '0;
      end else if (advance) begin
        s2_vld_q  <= s1_vld_q;
        s2_prod_q <= prod_c;
        s2_mode_q <= mode1_q;
      end
    end

    countone_mul_delay #(
      .DEPTH (STAGES - 3),
      .W     (PW + 2)
    ) u_delay (
      .clk   (clk),
      .reset (reset),
      .adv_i (advance),
      .vld_i (s2_vld_q),
      .dat_i ({s2_mode_q, s2_prod_q}),
      .vld_o (fin_vld),
      .dat_o (fin_dat)
    );

    assign fin_mode = fin_dat[PW+1:PW];
    assign fin_prod = fin_dat[PW-1:0];
  end

  // Final stage: the accumulator register doubles as the output data register.
  logic [ACC_WIDTH-1:0] prod_ext, acc_d, acc_q;
  logic                 out_vld_q;

  always_comb begin
    prod_ext         = '0;
    prod_ext[PW-1:0] = fin_prod;
    for (int i = PW; i < ACC_WIDTH; i++) prod_ext[i] = fin_mode.signed_en & fin_prod[PW-1];
    acc_d = fin_mode.acc_en ? acc_q + prod_ext : prod_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      acc_q     <= '0;
    end else if (advance) begin
      out_vld_q <= fin_vld;
      if (fin_vld) acc_q <= acc_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_countone_mul_pipe.sv
// Bench for countone_mul_pipe: directed table, handshake/reset/ce sequences and random traffic
// checked against a slot-based arithmetic model; a 32-bit-accumulator copy checks wrap.
module tb_countone_mul_pipe;

  localparam int S = 4;

  logic clk, reset, ce, in_valid, in_signed, in_acc, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, in_ready32, out_valid32;
  logic [39:0] out_data;
  logic [31:0] out_data32;

  countone_mul_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  countone_mul_pipe #(.ACC_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted beat's result is fixed at accept time (results apply in order),
  // then rides S slots that all shift together whenever the pipe advances.
  logic        mv [1:S];
  logic [39:0] md [1:S];
  logic [39:0] macc;
  logic        last_acc;
  logic [39:0] got [$];
  logic [31:0] got32 [$];

  task automatic model_clear();
    for (int i = 1; i <= S; i++) begin mv[i] = 1'b0; md[i] = '0; end
    macc = '0;
  endtask

  function automatic logic model_rdy();
    return ce && !(mv[S] && !out_ready);
  endfunction

  task automatic model_update();
    longint pa, pb;
    logic [63:0] res;
    if (reset) begin model_clear(); return; end
    if (model_rdy()) begin
      for (int i = S; i >= 2; i--) begin mv[i] = mv[i-1]; md[i] = md[i-1]; end
      mv[1] = in_valid;
      if (in_valid) begin
        if (in_signed) begin pa = longint'($signed(in_a)); pb = longint'($signed(in_b)); end
        else begin pa = longint'(in_a); pb = longint'(in_b); end
        res = 64'(pa * pb) + (in_acc ? {24'd0, macc} : 64'd0);
        md[1] = res[39:0];
        macc  = res[39:0];
      end
    end
  endtask

  task automatic tick();
    #1;
    chk("in_ready", in_ready, model_rdy());
    chk("in_ready32", in_ready32, model_rdy());
    last_acc = in_valid && model_rdy();
    if (ce && out_valid && out_ready) begin
      got.push_back(out_data);
      got32.push_back(out_data32);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("out_valid", out_valid, mv[S]);
    chk("out_valid32", out_valid32, mv[S]);
    if (mv[S]) begin
      chk("out_data", out_data, md[S]);
      chk("out_data32", out_data32, md[S][31:0]);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        acc;
    logic [39:0] exp;
  } vec_t;

  vec_t tbl [10];
  int   lat;
  int   k;

  initial begin
    tbl[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'h00FFFE0001};
    tbl[1] = '{16'hFFFF, 16'h0003, 1'b1, 1'b0, 40'hFFFFFFFFFD};
    tbl[2] = '{16'hFFFF, 16'h0003, 1'b0, 1'b0, 40'h000002FFFD};
    tbl[3] = '{16'h0002, 16'h0003, 1'b0, 1'b0, 40'd6};
    tbl[4] = '{16'h0004, 16'h0005, 1'b0, 1'b1, 40'd26};
    tbl[5] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 40'd27};
    tbl[6] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 40'hFFFFFFFFFF};
    tbl[7] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 40'h0000000000};
    tbl[8] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 40'h0040000000};
    tbl[9] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 40'hFFC0008000};

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_acc = 1'b0; out_ready = 1'b1;
    model_clear();
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 40'd0);
    chk("rst_out_data32", out_data32, 32'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed table, back-to-back beats at full throughput.
    got.delete(); got32.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = tbl[i].a; in_b = tbl[i].b;
      in_signed = tbl[i].sgn; in_acc = tbl[i].acc;
      tick();
    end
    in_valid = 1'b0;
    repeat (S + 2) tick();
    chk("tbl_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      chk("tbl_data", got[i], tbl[i].exp);
      chk("tbl_data32", got32[i], tbl[i].exp[31:0]);
    end

    // Backpressure: out_ready toggles every cycle, in_valid held until accepted.
    got.delete(); got32.delete();
    k = 1;
    for (int c = 0; c < 60; c++) begin
      out_ready = c[0];
      in_valid = (k <= 8); in_a = 16'(k); in_b = 16'(k);
      in_signed = 1'b0; in_acc = 1'b0;
      tick();
      if (last_acc) k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) tick();
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_square", got[i], 40'((i + 1) * (i + 1)));

    // Reset with beats in flight: output drops at once and nothing stale emerges.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 16'(3 + i); in_b = 16'd2; in_signed = 1'b0; in_acc = 1'b1;
      tick();
    end
    chk("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_data", out_data, 40'd0);
    chk("async_rst_valid32", out_valid32, 1'b0);
    model_clear();
    tick(); tick();
    reset = 1'b0; out_ready = 1'b1;
    got.delete(); got32.delete();
    repeat (8) tick();
    chk("post_rst_outputs", got.size(), 0);

    // ce low for 5 cycles while a beat is in flight stretches latency by exactly 5.
    in_valid = 1'b1; in_a = 16'd7; in_b = 16'd9; in_signed = 1'b0; in_acc = 1'b0;
    tick(); lat = 1;
    in_valid = 1'b0;
    tick(); lat++;
    ce = 1'b0;
    repeat (5) begin tick(); lat++; end
    ce = 1'b1;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    chk("ce_latency", lat, 9);
    chk("ce_data", out_data, 40'd63);

    // Random traffic: mixed modes, accumulate, ce and backpressure.
    for (int c = 0; c < 600; c++) begin
      ce        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      in_a      = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      in_signed = $urandom_range(0, 1) != 0;
      in_acc    = $urandom_range(0, 1) != 0;
      tick();
    end
    ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    repeat (S + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
